// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard/sequencing bundle between the 5-stage datapath
// and pipeline_ctrl.
//   master : datapath side; drives the stage status, observes the controls
//   slave  : controller side; observes the stage status, drives the controls
// Status : ihit, dhit, exmem_dMemREN, exmem_dMemWEN, exmem_Halt, redirect,
//          idex_dMemREN, idex_rt, ifid_rs, ifid_rt
// Control: pc_wen, {ifid,idex,exmem,memwb}_wen, {ifid,idex,exmem,memwb}_flush,
//          halt, state (debug), stall_cycles, flush_events (perf counters)
interface pipeline_ctrl_if #(
   parameter int unsigned REGBITS = 5,
   parameter int unsigned CNT_W   = 32
);
   logic               ihit;
   logic               dhit;
   logic               exmem_dMemREN;
   logic               exmem_dMemWEN;
   logic               exmem_Halt;
   logic               redirect;
   logic               idex_dMemREN;
   logic [REGBITS-1:0] idex_rt;
   logic [REGBITS-1:0] ifid_rs;
   logic [REGBITS-1:0] ifid_rt;

   logic               pc_wen;
   logic               ifid_wen;
   logic               idex_wen;
   logic               exmem_wen;
   logic               memwb_wen;
   logic               ifid_flush;
   logic               idex_flush;
   logic               exmem_flush;
   logic               memwb_flush;
   logic               halt;
   logic [1:0]         state;
   logic [CNT_W-1:0]   stall_cycles;
   logic [CNT_W-1:0]   flush_events;

   modport master (
      output ihit, dhit, exmem_dMemREN, exmem_dMemWEN, exmem_Halt, redirect,
             idex_dMemREN, idex_rt, ifid_rs, ifid_rt,
      input  pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen,
             ifid_flush, idex_flush, exmem_flush, memwb_flush,
             halt, state, stall_cycles, flush_events
   );

   modport slave (
      input  ihit, dhit, exmem_dMemREN, exmem_dMemWEN, exmem_Halt, redirect,
             idex_dMemREN, idex_rt, ifid_rs, ifid_rt,
      output pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen,
             ifid_flush, idex_flush, exmem_flush, memwb_flush,
             halt, state, stall_cycles, flush_events
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and sequencing controller for the 5-stage pipeline.
// Resolves, in priority order, D-memory wait, control redirect, load-use
// hazard and I-fetch miss, and sequences the end-of-program halt drain.
// Ports:
//   CLK  - system clock, all state changes on the rising edge
//   RST  - synchronous active-high reset; forces every wen/flush/halt low
//   bus  - pipeline_ctrl_if.slave: stage status in, register controls out
// Optional build macro PIPE_PERF_EN adds the stall_cycles / flush_events
// counters; without it both outputs are constant zero and no flops exist.
module pipeline_ctrl #(
   parameter int unsigned REGBITS = 5,
   parameter int unsigned CNT_W   = 32
) (
   input  logic            CLK,
   input  logic            RST,
   pipeline_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DWAIT  = 2'd1,
      DRAIN  = 2'd2,
      HALTED = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic               pend_q, pend_d;

   logic [REGBITS-1:0] idex_rt, ifid_rs, ifid_rt;
   logic               fetch_ok, mem_busy, load_use, waiting;
   logic               redirect_taken;

   logic pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen;
   logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
   logic halt;

   assign idex_rt = bus.idex_rt;
   assign ifid_rs = bus.ifid_rs;
   assign ifid_rt = bus.ifid_rt;

   always_comb begin
      fetch_ok = bus.ihit | pend_q;
      mem_busy = (bus.exmem_dMemREN | bus.exmem_dMemWEN) & ~bus.dhit;
      load_use = bus.idex_dMemREN & (idex_rt != '0) &
                 ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));
   end

   always_comb begin
      pc_wen         = 1'b1;
      ifid_wen       = 1'b1;
      idex_wen       = 1'b1;
      exmem_wen      = 1'b1;
      memwb_wen      = 1'b1;
      ifid_flush     = 1'b0;
      idex_flush     = 1'b0;
      exmem_flush    = 1'b0;
      memwb_flush    = 1'b0;
      halt           = 1'b0;
      redirect_taken = 1'b0;
      waiting        = 1'b0;
      state_d        = state_q;

      unique case (state_q)
         RUN, DWAIT: begin
            // Once in DWAIT only dhit releases the stall; RUN must see the
            // memory op itself before stalling.
            waiting = (state_q == DWAIT) ? ~bus.dhit : mem_busy;
            state_d = RUN;
            if (waiting) begin
               pc_wen      = 1'b0;
               ifid_wen    = 1'b0;
               idex_wen    = 1'b0;
               exmem_wen   = 1'b0;
               memwb_flush = 1'b1;
               state_d     = DWAIT;
            end else if (bus.exmem_Halt) begin
               pc_wen      = 1'b0;
               ifid_flush  = 1'b1;
               idex_flush  = 1'b1;
               exmem_flush = 1'b1;
               state_d     = DRAIN;
            end else if (bus.redirect) begin
               ifid_flush     = 1'b1;
               idex_flush     = 1'b1;
               exmem_flush    = 1'b1;
               redirect_taken = 1'b1;
            end else if (load_use) begin
               pc_wen     = 1'b0;
               ifid_wen   = 1'b0;
               idex_flush = 1'b1;
            end else if (!fetch_ok) begin
               pc_wen     = 1'b0;
               ifid_flush = 1'b1;
            end
         end
         DRAIN: begin
            // Only MEM/WB advances so the halt instruction retires.
            pc_wen    = 1'b0;
            ifid_wen  = 1'b0;
            idex_wen  = 1'b0;
            exmem_wen = 1'b0;
            state_d   = HALTED;
         end
         HALTED: begin
            pc_wen    = 1'b0;
            ifid_wen  = 1'b0;
            idex_wen  = 1'b0;
            exmem_wen = 1'b0;
            memwb_wen = 1'b0;
            halt      = 1'b1;
         end
         default: state_d = RUN;
      endcase

      if (RST) begin
         pc_wen         = 1'b0;
         ifid_wen       = 1'b0;
         idex_wen       = 1'b0;
         exmem_wen      = 1'b0;
         memwb_wen      = 1'b0;
         ifid_flush     = 1'b0;
         idex_flush     = 1'b0;
         exmem_flush    = 1'b0;
         memwb_flush    = 1'b0;
         halt           = 1'b0;
         redirect_taken = 1'b0;
         state_d        = RUN;
      end
   end

   // A fetch that completes while the PC is held is remembered so the next
   // advancing cycle uses it; any PC update (including a redirect) drops it.
   always_comb begin
      if (pc_wen | redirect_taken) begin
         pend_d = 1'b0;
      end else if (bus.ihit) begin
         pend_d = 1'b1;
      end else begin
         pend_d = pend_q;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= RUN;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
      end
   end

   assign bus.pc_wen      = pc_wen;
   assign bus.ifid_wen    = ifid_wen;
   assign bus.idex_wen    = idex_wen;
   assign bus.exmem_wen   = exmem_wen;
   assign bus.memwb_wen   = memwb_wen;
   assign bus.ifid_flush  = ifid_flush;
   assign bus.idex_flush  = idex_flush;
   assign bus.exmem_flush = exmem_flush;
   assign bus.memwb_flush = memwb_flush;
   assign bus.halt        = halt;
   assign bus.state       = state_q;

`ifdef PIPE_PERF_EN
   logic [CNT_W-1:0] stall_q, flush_q;
   logic             stall_ev, flush_ev;

   // Halt and redirect are the only rules that flush IF/ID and ID/EX together.
   always_comb begin
      stall_ev = ~pc_wen & ((state_q == RUN) | (state_q == DWAIT));
      flush_ev = ifid_flush & idex_flush;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (stall_ev) stall_q <= stall_q + 1'b1;
         if (flush_ev) flush_q <= flush_q + 1'b1;
      end
   end

   assign bus.stall_cycles = stall_q;
   assign bus.flush_events = flush_q;
`else
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;
   assign bus.stall_cycles = CNT_ZERO;
   assign bus.flush_events = CNT_ZERO;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed scenarios plus randomized traffic against a
// behavioural model of the controller's priority rules.
module tb_pipeline_ctrl;
   localparam int unsigned REGBITS = 5;
   localparam int unsigned CNT_W   = 32;
`ifdef PIPE_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   // {pc, ifid, idex, exmem, memwb wen, ifid, idex, exmem, memwb flush, halt}
   localparam logic [9:0] V_ZERO   = 10'b00000_0000_0;
   localparam logic [9:0] V_NORMAL = 10'b11111_0000_0;
   localparam logic [9:0] V_LDUSE  = 10'b00111_0100_0;
   localparam logic [9:0] V_DMISS  = 10'b00001_0001_0;
   localparam logic [9:0] V_REDIR  = 10'b11111_1110_0;
   localparam logic [9:0] V_HALT1  = 10'b01111_1110_0;
   localparam logic [9:0] V_DRAIN  = 10'b00001_0000_0;
   localparam logic [9:0] V_HALTED = 10'b00000_0000_1;
   localparam logic [9:0] V_IMISS  = 10'b01111_1000_0;

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   pipeline_ctrl_if #(.REGBITS(REGBITS), .CNT_W(CNT_W)) bus ();
   pipeline_ctrl #(.REGBITS(REGBITS), .CNT_W(CNT_W)) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   int passed = 0;
   int total  = 0;

   int               m_state;
   bit               m_pend;
   logic [CNT_W-1:0] m_stall, m_flush;

   function automatic logic [9:0] dut_vec();
      return {bus.pc_wen, bus.ifid_wen, bus.idex_wen, bus.exmem_wen, bus.memwb_wen,
              bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush, bus.halt};
   endfunction

   // Expected controls for the current inputs, plus the model's next state.
   function automatic void model_eval(output logic [9:0] v, output int nxt,
                                      output bit npend, output bit s_inc,
                                      output bit f_inc);
      bit pc, fw, dw, xw, mw, ff, df, xf, mf, h, wait_mem, lu;
      {pc, fw, dw, xw, mw} = 5'b11111;
      {ff, df, xf, mf, h}  = 5'b00000;
      f_inc = 1'b0;
      nxt   = m_state;
      if (RST) begin
         v = '0; nxt = 0; npend = 1'b0; s_inc = 1'b0;
         return;
      end
      if (m_state == 3) begin
         {pc, fw, dw, xw, mw} = 5'b00000;
         h = 1'b1;
      end else if (m_state == 2) begin
         {pc, fw, dw, xw} = 4'b0000;
         nxt = 3;
      end else begin
         wait_mem = (m_state == 1) ? !bus.dhit
                                   : ((bus.exmem_dMemREN || bus.exmem_dMemWEN) && !bus.dhit);
         lu = bus.idex_dMemREN && (bus.idex_rt != 0) &&
              (bus.idex_rt == bus.ifid_rs || bus.idex_rt == bus.ifid_rt);
         nxt = 0;
         if (wait_mem) begin
            {pc, fw, dw, xw} = 4'b0000; mf = 1'b1; nxt = 1;
         end else if (bus.exmem_Halt) begin
            pc = 1'b0; {ff, df, xf} = 3'b111; nxt = 2; f_inc = 1'b1;
         end else if (bus.redirect) begin
            {ff, df, xf} = 3'b111; f_inc = 1'b1;
         end else if (lu) begin
            pc = 1'b0; fw = 1'b0; df = 1'b1;
         end else if (!(bus.ihit || m_pend)) begin
            pc = 1'b0; ff = 1'b1;
         end
      end
      npend = pc ? 1'b0 : (bus.ihit ? 1'b1 : m_pend);
      s_inc = (m_state < 2) && !pc;
      v = {pc, fw, dw, xw, mw, ff, df, xf, mf, h};
   endfunction

   task automatic tick();
      logic [9:0] v;
      int n;
      bit p, s, f;
      model_eval(v, n, p, s, f);
      @(posedge CLK);
      if (RST) begin
         m_stall = '0; m_flush = '0;
      end else begin
         m_stall = m_stall + CNT_W'(s);
         m_flush = m_flush + CNT_W'(f);
      end
      m_state = n;
      m_pend  = p;
      #1;
   endtask

   task automatic set_idle();
      bus.ihit = 1'b0; bus.dhit = 1'b0;
      bus.exmem_dMemREN = 1'b0; bus.exmem_dMemWEN = 1'b0;
      bus.exmem_Halt = 1'b0; bus.redirect = 1'b0;
      bus.idex_dMemREN = 1'b0; bus.idex_rt = '0;
      bus.ifid_rs = '0; bus.ifid_rt = '0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      set_idle();
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         total++;
         if (dut_vec() !== V_ZERO) $display("FAIL reset_ctrl got=%b exp=%b", dut_vec(), V_ZERO);
         else passed++;
         total++;
         if (bus.state !== 2'd0) $display("FAIL reset_state got=%0d exp=0", bus.state);
         else passed++;
         total++;
         if (bus.stall_cycles !== '0 || bus.flush_events !== '0)
            $display("FAIL reset_cnt got=%0d/%0d exp=0/0", bus.stall_cycles, bus.flush_events);
         else passed++;
         tick();
      end
      RST = 1'b0;
      bus.ihit = 1'b1;
      @(negedge CLK);
      total++;
      if (dut_vec() !== V_NORMAL) $display("FAIL post_reset got=%b exp=%b", dut_vec(), V_NORMAL);
      else passed++;
      tick();
   endtask

   task automatic test_load_use();
      set_idle();
      bus.idex_dMemREN = 1'b1; bus.idex_rt = 5'd8; bus.ifid_rs = 5'd8; bus.ihit = 1'b1;
      @(negedge CLK);
      total++;
      if (dut_vec() !== V_LDUSE) $display("FAIL lduse_rs got=%b exp=%b", dut_vec(), V_LDUSE);
      else passed++;
      tick();
      // fetch captured during the stall must let the next cycle advance
      set_idle();
      @(negedge CLK);
      total++;
      if (dut_vec() !== V_NORMAL) $display("FAIL lduse_pend got=%b exp=%b", dut_vec(), V_NORMAL);
      else passed++;
      tick();
      bus.idex_dMemREN = 1'b1; bus.idex_rt = '0; bus.ifid_rs = '0; bus.ihit = 1'b1;
      @(negedge CLK);
      total++;
      if (dut_vec() !== V_NORMAL) $display("FAIL lduse_r0 got=%b exp=%b", dut_vec(), V_NORMAL);
      else passed++;
      tick();
      bus.idex_rt = 5'd5; bus.ifid_rs = 5'd3; bus.ifid_rt = 5'd5;
      @(negedge CLK);
      total++;
      if (dut_vec() !== V_LDUSE) $display("FAIL lduse_rt got=%b exp=%b", dut_vec(), V_LDUSE);
      else passed++;
      tick();
      set_idle();
      bus.ihit = 1'b1;
      tick();
   endtask

   task automatic test_dmiss();
      logic [1:0] exp_st [3] = '{2'd0, 2'd1, 2'd1};
      set_idle();
      bus.exmem_dMemREN = 1'b1;
      for (int c = 0; c < 3; c++) begin
         bus.ihit = (c == 1);
         @(negedge CLK);
         total++;
         if (dut_vec() !== V_DMISS || bus.state !== exp_st[c])
            $display("FAIL dmiss_c%0d got=%b/%0d exp=%b/%0d", c, dut_vec(), bus.state, V_DMISS, exp_st[c]);
         else passed++;
         tick();
      end
      bus.ihit = 1'b0; bus.dhit = 1'b1;
      @(negedge CLK);
      total++;
      if (dut_vec() !== V_NORMAL) $display("FAIL dmiss_release got=%b exp=%b", dut_vec(), V_NORMAL);
      else passed++;
      tick();
      set_idle();
      @(negedge CLK);
      total++;
      if (bus.state !== 2'd0) $display("FAIL dmiss_return got=%0d exp=0", bus.state);
      else passed++;
      // the captured fetch was used by the release cycle; no second use
      total++;
      if (dut_vec() !== V_IMISS) $display("FAIL dmiss_once got=%b exp=%b", dut_vec(), V_IMISS);
      else passed++;
      tick();
   endtask

   task automatic test_redirect_load_use();
      set_idle();
      bus.redirect = 1'b1; bus.idex_dMemREN = 1'b1; bus.idex_rt = 5'd4; bus.ifid_rs = 5'd4;
      @(negedge CLK);
      total++;
      if (dut_vec() !== V_REDIR) $display("FAIL redir_lduse got=%b exp=%b", dut_vec(), V_REDIR);
      else passed++;
      tick();
      set_idle();
      bus.ihit = 1'b1;
      tick();
   endtask

   task automatic test_halt();
      set_idle();
      // a pending store masks halt and redirect until dhit
      bus.exmem_Halt = 1'b1; bus.redirect = 1'b1; bus.exmem_dMemWEN = 1'b1;
      @(negedge CLK);
      total++;
      if (dut_vec() !== V_DMISS) $display("FAIL halt_masked got=%b exp=%b", dut_vec(), V_DMISS);
      else passed++;
      tick();
      bus.dhit = 1'b1;
      @(negedge CLK);
      total++;
      if (dut_vec() !== V_HALT1) $display("FAIL halt_c1 got=%b exp=%b", dut_vec(), V_HALT1);
      else passed++;
      tick();
      set_idle();
      @(negedge CLK);
      total++;
      if (dut_vec() !== V_DRAIN || bus.state !== 2'd2)
         $display("FAIL halt_drain got=%b/%0d exp=%b/2", dut_vec(), bus.state, V_DRAIN);
      else passed++;
      tick();
      for (int c = 0; c < 10; c++) begin
         bus.ihit = 1'($urandom); bus.redirect = 1'($urandom); bus.exmem_Halt = 1'($urandom);
         @(negedge CLK);
         total++;
         if (dut_vec() !== V_HALTED || bus.state !== 2'd3)
            $display("FAIL halt_hold%0d got=%b/%0d exp=%b/3", c, dut_vec(), bus.state, V_HALTED);
         else passed++;
         tick();
      end
      set_idle();
      RST = 1'b1;
      tick();
      RST = 1'b0;
   endtask

   task automatic test_perf();
      set_idle();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge CLK);
         total++;
         if (dut_vec() !== V_IMISS) $display("FAIL perf_imiss%0d got=%b exp=%b", c, dut_vec(), V_IMISS);
         else passed++;
         tick();
      end
      bus.redirect = 1'b1;
      @(negedge CLK);
      total++;
      if (dut_vec() !== V_REDIR) $display("FAIL perf_redir got=%b exp=%b", dut_vec(), V_REDIR);
      else passed++;
      tick();
      set_idle();
      bus.ihit = 1'b1;
      @(negedge CLK);
      total++;
      if (bus.stall_cycles !== (PERF ? CNT_W'(4) : CNT_W'(0)))
         $display("FAIL perf_stall got=%0d exp=%0d", bus.stall_cycles, PERF ? 4 : 0);
      else passed++;
      total++;
      if (bus.flush_events !== (PERF ? CNT_W'(1) : CNT_W'(0)))
         $display("FAIL perf_flush got=%0d exp=%0d", bus.flush_events, PERF ? 1 : 0);
      else passed++;
      tick();
   endtask

   task automatic test_random();
      logic [9:0] v;
      int n;
      bit p, s, f;
      int halted_run = 0;
      for (int c = 0; c < 800; c++) begin
         RST = ($urandom_range(0, 99) < 2) || (halted_run > 4);
         bus.ihit          = ($urandom_range(0, 99) < 70);
         bus.dhit          = ($urandom_range(0, 99) < 50);
         bus.exmem_dMemREN = ($urandom_range(0, 99) < 20);
         bus.exmem_dMemWEN = ($urandom_range(0, 99) < 10);
         bus.exmem_Halt    = ($urandom_range(0, 99) < 3);
         bus.redirect      = ($urandom_range(0, 99) < 10);
         bus.idex_dMemREN  = ($urandom_range(0, 99) < 40);
         bus.idex_rt       = REGBITS'($urandom_range(0, 3));
         bus.ifid_rs       = REGBITS'($urandom_range(0, 3));
         bus.ifid_rt       = REGBITS'($urandom_range(0, 3));
         @(negedge CLK);
         model_eval(v, n, p, s, f);
         total++;
         if (dut_vec() !== v) $display("FAIL rand_ctrl c=%0d got=%b exp=%b", c, dut_vec(), v);
         else passed++;
         total++;
         if (bus.state !== 2'(m_state)) $display("FAIL rand_state c=%0d got=%0d exp=%0d", c, bus.state, m_state);
         else passed++;
         total++;
         if (bus.stall_cycles !== (PERF ? m_stall : '0) || bus.flush_events !== (PERF ? m_flush : '0))
            $display("FAIL rand_cnt c=%0d got=%0d/%0d exp=%0d/%0d", c, bus.stall_cycles,
                     bus.flush_events, PERF ? m_stall : '0, PERF ? m_flush : '0);
         else passed++;
         halted_run = (m_state == 3) ? halted_run + 1 : 0;
         tick();
      end
      RST = 1'b0;
   endtask

   initial begin
      m_state = 0; m_pend = 1'b0; m_stall = '0; m_flush = '0;
      test_reset();
      test_load_use();
      test_dmiss();
      test_redirect_load_use();
      test_halt();
      test_perf();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
